// File: rtl/pipe_pkg.sv
// Shared encodings for the pipe_issue_ctrl slice: instruction fields, the NOP
// constant and the register-index type.
package pipe_pkg;

  typedef logic [1:0] reg_idx_t;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [7:0] NOP_INST = 8'h00;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS1_HI = 5;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 2;
  localparam int RD_HI  = 1;
  localparam int RD_LO  = 0;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous pointer FIFO for 8-bit instructions. The head is read straight
// from storage, so a pushed entry becomes visible the cycle after its push.
module inst_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: buffers instructions, tracks pending writebacks
// per register and injects NOPs into pipeline_v while a RAW/WAW hazard holds.
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_inst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  out_inst,
  output logic        out_valid,
  output logic [15:0] stall_cnt,
  output logic        busy
);

  localparam int CW = $clog2(WB_LAT + 1);

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic       push;
  logic       issue;
  logic       hazard;
  logic       sb_pending;

  logic [CW-1:0] cnt [NUM_REGS];

  logic [1:0] head_op;
  reg_idx_t   head_rs1;
  reg_idx_t   head_rs2;
  reg_idx_t   head_rd;

  assign head_op  = head[OP_HI:OP_LO];
  assign head_rs1 = head[RS1_HI:RS1_LO];
  assign head_rs2 = head[RS2_HI:RS2_LO];
  assign head_rd  = head[RD_HI:RD_LO];

  assign in_ready = !rst && !fifo_full;
  assign push     = in_valid && in_ready && !flush;
  assign issue    = !fifo_empty && !hazard && !flush;

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .flush (flush),
    .din   (in_inst),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Checking rd as well as the sources keeps a younger write from landing
  // before an older one to the same register.
  always_comb begin
    hazard     = 1'b0;
    sb_pending = 1'b0;
    if (head_op != OP_NOP) begin
      hazard = (cnt[head_rs1] != '0) || (cnt[head_rs2] != '0) || (cnt[head_rd] != '0);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt[r] != '0) sb_pending = 1'b1;
    end
  end

  assign busy = !fifo_empty || sb_pending;

  // Flush leaves the scoreboard alone: writes already issued still land.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue && (head_op != OP_NOP) && (head_rd == reg_idx_t'(r))) begin
          cnt[r] <= CW'(WB_LAT);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst  <= NOP_INST;
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      out_inst  <= issue ? head : NOP_INST;
      out_valid <= issue;
      if (!fifo_empty && hazard && !flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: inputs change and outputs are sampled on
// the falling edge, half a period away from the active edge.
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_inst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [7:0]  out_inst;
  logic        out_valid;
  logic [15:0] stall_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(4), .WB_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_inst   (in_inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_inst  (out_inst),
    .out_valid (out_valid),
    .stall_cnt (stall_cnt),
    .busy      (busy)
  );

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_drain: busy=%b required 0 within 30 cycles", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = 8'h00; flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_inst !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_out_inst: got %h want 00", out_inst); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_in_ready_hi: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_in_ready_lo: got %b want 1", in_ready); end
  endtask

  task automatic test_independent();
    in_valid = 1'b1; in_inst = 8'h41;
    @(negedge clk);
    in_inst = 8'h6B;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h41) begin n_bad++; $display("[TB] FAIL indep_first: got %b/%h want 1/41", out_valid, out_inst); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h6B) begin n_bad++; $display("[TB] FAIL indep_second: got %b/%h want 1/6b", out_valid, out_inst); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL indep_stall: got %0d want 0", stall_cnt); end
    wait_idle("indep");
  endtask

  task automatic test_raw_stall();
    in_valid = 1'b1; in_inst = 8'h41;
    @(negedge clk);
    in_inst = 8'h52;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h41) begin n_bad++; $display("[TB] FAIL raw_producer: got %b/%h want 1/41", out_valid, out_inst); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out_inst !== 8'h00) begin
        n_bad++; $display("[TB] FAIL raw_bubble%0d: got %b/%h want 0/00", i, out_valid, out_inst);
      end
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h52) begin n_bad++; $display("[TB] FAIL raw_consumer: got %b/%h want 1/52", out_valid, out_inst); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL raw_stall_cnt: got %0d want 3", stall_cnt); end
    wait_idle("raw");
  endtask

  task automatic test_nop_op();
    in_valid = 1'b1; in_inst = 8'h03;
    @(negedge clk);
    in_inst = 8'hCC;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h03) begin n_bad++; $display("[TB] FAIL nop_first: got %b/%h want 1/03", out_valid, out_inst); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'hCC) begin n_bad++; $display("[TB] FAIL nop_second: got %b/%h want 1/cc", out_valid, out_inst); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL nop_stall_cnt: got %0d want 3", stall_cnt); end
    wait_idle("nop");
  endtask

  task automatic test_back_to_back_full();
    int sent, got, first_full, prev_cyc;
    logic fire;
    sent = 0; got = 0; first_full = -1; prev_cyc = -1;
    in_valid = 1'b1; in_inst = 8'h41;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      fire = in_valid && in_ready;
      if (in_valid && !in_ready && first_full < 0) first_full = cyc;
      @(negedge clk);
      if (fire) sent++;
      if (sent == 6) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (out_inst !== 8'h41) begin n_bad++; $display("[TB] FAIL full_data%0d: got %h want 41", got, out_inst); end
        n_cmp++;
        if (prev_cyc < 0 && cyc !== 2) begin
          n_bad++; $display("[TB] FAIL full_first_issue: got cycle %0d want 2", cyc);
        end else if (prev_cyc >= 0 && cyc - prev_cyc !== 4) begin
          n_bad++; $display("[TB] FAIL full_spacing%0d: got %0d want 4", got, cyc - prev_cyc);
        end
        prev_cyc = cyc;
      end
    end
    n_cmp++; if (sent !== 6) begin n_bad++; $display("[TB] FAIL full_sent: got %0d want 6", sent); end
    n_cmp++; if (got !== 6) begin n_bad++; $display("[TB] FAIL full_got: got %0d want 6", got); end
    n_cmp++; if (first_full !== 6) begin n_bad++; $display("[TB] FAIL full_ready_drop: got cycle %0d want 6", first_full); end
    n_cmp++; if (stall_cnt !== 16'd18) begin n_bad++; $display("[TB] FAIL full_stall_cnt: got %0d want 18", stall_cnt); end
    wait_idle("full");
  endtask

  task automatic test_flush_during_stall();
    in_valid = 1'b1; in_inst = 8'h41;
    @(negedge clk);
    in_inst = 8'h52;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_inst !== 8'h41) begin n_bad++; $display("[TB] FAIL flush_producer: got %h want 41", out_inst); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_busy0: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_busy1: got %b/%b want 1/0", busy, out_valid); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_busy2: got %b/%b want 0/0", busy, out_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_no_emit%0d: got %b/%h want 0/00", i, out_valid, out_inst); end
    end
    n_cmp++; if (stall_cnt !== 16'd18) begin n_bad++; $display("[TB] FAIL flush_stall_cnt: got %0d want 18", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_inst = 8'h41;
    @(negedge clk);
    in_inst = 8'h46;
    @(negedge clk);
    in_inst = 8'h62;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_full: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 8'h46) begin n_bad++; $display("[TB] FAIL mid_producer: got %b/%h want 1/46", out_valid, out_inst); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_inst !== 8'h00 || out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_out: got %b/%h want 0/00", out_valid, out_inst); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL mid_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_after%0d: got %b/%b want 0/0", i, out_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_stall();
    test_nop_op();
    test_back_to_back_full();
    test_flush_during_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

In-order issue controller that sits in front of `pipeline_v`, the 8-bit, 4-register pipeline. It buffers incoming instructions in a small FIFO and tracks pending register writebacks with a per-register scoreboard. It stalls any RAW or WAW hazard and drives the pipeline's `inst` input, injecting NOPs (8'h00) whenever nothing can issue.

## Interface
- `DEPTH`, 4: instruction FIFO entries; power of two, ≥2.
- `WB_LAT`, 3: cycles from issue until the destination register is written; range 1..7.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_inst`  in  8  instruction from the source.
- `in_valid`  in  1  `in_inst` valid.
- `in_ready`  out  1  FIFO can accept an instruction.
- `flush`  in  1  drop every queued instruction.
- `out_inst`  out  8  drives `pipeline_v.inst`.
- `out_valid`  out  1  `out_inst` is a real issued instruction, not an injected NOP.
- `stall_cnt`  out  16  saturating count of hazard-stall cycles.
- `busy`  out  1  FIFO non-empty or any scoreboard entry non-zero.

## Operation
- Instruction fields:
  - `[7:6]` op; op 2'b00 is NOP and performs no register write.
  - `[5:4]` rs1, `[3:2]` rs2, `[1:0]` rd.
- Enqueue occurs when `in_valid && in_ready && !flush`.
  - `in_ready = !rst && (occupancy < DEPTH)`.
  - There is no bypass: an entry is visible at the FIFO head the cycle after its enqueue edge.
- Scoreboard: one down-counter per register, `cnt[0..3]`, each of width clog2(WB_LAT+1).
  - Every non-zero counter decrements by 1 each cycle.
  - Issuing an op≠00 instruction loads `cnt[rd] = WB_LAT`; the load wins over the decrement.
- Hazard at head, for op≠00: `cnt[rs1]≠0 || cnt[rs2]≠0 || cnt[rd]≠0`.
- Hazard at head, for op=00: never a hazard.
- Issue condition: head valid && !hazard && !flush.
  - On issue, pop the head, register `out_inst = head` and `out_valid = 1`.
  - Otherwise register `out_inst = 8'h00` and `out_valid = 0`.
- `stall_cnt` increments on each cycle with head valid && hazard && !flush; it saturates at 16'hFFFF.
- `flush`:
  - Empties the FIFO at the next edge and suppresses issue and enqueue in that same cycle.
  - The scoreboard is not cleared, because in-flight writes still complete.
- No state machine beyond FIFO occupancy plus the scoreboard; the controller is either issuing, stalling (hazard) or idle (empty).

## Timing
- Reset values (one edge with `rst` high):
  - FIFO empty; all `cnt` = 0; `stall_cnt` = 0.
  - `out_inst` = 8'h00, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 the first cycle after.
- Reset mid-operation discards queued and pending state completely; `stall_cnt` is cleared by `rst` only.
- Latency:
  - Enqueue at edge E into an empty, hazard-free FIFO gives `out_valid` after edge E+1.
  - A dependent instruction issues no earlier than producer issue edge + WB_LAT + 1, i.e. WB_LAT bubble cycles.
- Throughput: one instruction per cycle when there are no hazards.
- FIFO full: `in_ready` = 0; an issue in the same cycle frees a slot, so `in_ready` = 1 the following cycle.
- FIFO empty: issues NOPs continuously; `busy` falls once every `cnt` reaches 0.
- `busy`, `in_ready` and the hazard decision are combinational from registered state; all other outputs are registered.

## Structure
- `pipe_pkg` holds:
  - op encodings (OP_NOP = 2'b00) and field bit positions;
  - the NOP constant 8'h00;
  - a register-index type of 2 bits.
- Sub-module `inst_fifo` (parameter DEPTH; push/pop/flush; full/empty/head): synchronous pointer FIFO with wrap-around.
- The scoreboard and issue logic live in the top level.

## Test plan
- **Independent stream:** enqueue 0x41 then 0x6B on consecutive cycles → both emitted on consecutive cycles, `out_valid` = 1 on each; `stall_cnt` = 0.
- **RAW stall:** enqueue 0x41 then 0x52 (rs1 = r1) → 0x52 emitted 4 cycles after 0x41 with 3 `out_valid` = 0 NOP cycles in between; `stall_cnt` = 3.
- **NOP op:** enqueue 0x03 then 0xCC (reads r3) → 0xCC issues the cycle after 0x03 with no stall, since op 00 sets no scoreboard entry.
- **Full/back-pressure:** hold `in_valid` with 6 × 0x41 (WAW chain) → `in_ready` drops when occupancy reaches 4; all 6 are emitted, spaced 4 cycles apart; none are lost or duplicated.
- **Flush during stall:** assert `flush` for one cycle while 0x52 is stalled → 0x52 is never emitted; `out_valid` = 0; `busy` stays 1 until `cnt[1]` drains, then 0.
- **Reset mid-operation:** pulse `rst` with 3 entries queued and `cnt[2] = 2` → the next cycle shows the FIFO empty, `out_inst` = 8'h00, `stall_cnt` = 0 and `busy` = 0.
